// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the demux_stream slice.
//   demux_state_t : packet-lock FSM states (IDLE, LOCK)
//   CNT_W         : width of the per-channel delivered-beat counters
// Optional feature macro used by the slice: DEMUX_CNT_EN (per-channel beat counters).
package demux_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } demux_state_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register with valid/ready for a single channel.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture in_data/in_last this edge (wins over drain)
//   in_data, in_last    : beat to capture
//   ready               : downstream sink ready
//   out_data, out_last  : held beat (not zeroed when drained)
//   out_valid           : slot holds a beat
//   cnt                 : delivered-beat counter, only with DEMUX_CNT_EN
module demux_slot
   import demux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   input  logic             ready,
   output logic [W-1:0]     out_data,
   output logic             out_last,
   output logic             out_valid
`ifdef DEMUX_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt
`endif
);

   logic [W-1:0] data_r;
   logic         last_r;
   logic         valid_r;

   // Slot register: a load overrides a simultaneous drain so there is no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r  <= '0;
         last_r  <= 1'b0;
         valid_r <= 1'b0;
      end else if (load) begin
         data_r  <= in_data;
         last_r  <= in_last;
         valid_r <= 1'b1;
      end else if (ready) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

   assign out_data  = data_r;
   assign out_last  = last_r;
   assign out_valid = valid_r;

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_r;

   // Delivered-beat counter: counts output handshakes, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (valid_r && ready) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;
`endif

endmodule

// File: rtl/demux_stream.sv
// demux_stream: 1:N streaming demultiplexer with valid/ready handshake,
// a registered slot per channel and packet-level select locking.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_data/in_sel/in_last      : input beat, destination (sampled on packet start), end of packet
//   in_valid / in_ready         : input handshake (in_ready is combinational, independent of in_valid)
//   out_data[k*W +: W]          : channel k beat
//   out_last/out_valid/out_ready: per-channel flags and handshake
//   err                         : one-cycle pulse per beat dropped for an out-of-range select
//   beat_cnt[k*16 +: 16]        : per-channel delivered-beat counters, only with DEMUX_CNT_EN
module demux_stream
   import demux_pkg::*;
#(
   parameter  int W  = 4,
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [W-1:0]       in_data,
   input  logic [SW-1:0]      in_sel,
   input  logic               in_last,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [N*W-1:0]     out_data,
   output logic [N-1:0]       out_last,
   output logic [N-1:0]       out_valid,
   input  logic [N-1:0]       out_ready,
   output logic               err
`ifdef DEMUX_CNT_EN
   ,
   output logic [N*CNT_W-1:0] beat_cnt
`endif
);

   // N widened by one bit so the range check also works when N == 2**SW.
   localparam logic [SW:0] N_S = (SW+1)'(N);

   demux_state_t  state_r;
   demux_state_t  state_nxt_s;
   logic [SW-1:0] lock_sel_r;
   logic [SW-1:0] lock_sel_nxt_s;
   logic [SW-1:0] eff_sel_s;
   logic          in_range_s;
   logic          sel_ready_s;
   logic          in_xfer_s;
   logic          err_r;
   logic [N-1:0]  load_s;
   logic [N-1:0]  out_valid_s;

   // Effective select: live in_sel at packet start, latched select inside a packet.
   always_comb begin
      eff_sel_s = in_sel;
      case (state_r)
         IDLE:    eff_sel_s = in_sel;
         LOCK:    eff_sel_s = lock_sel_r;
         default: eff_sel_s = in_sel;
      endcase
   end

   // Readiness mux: an out-of-range select matches no slot and stays ready so the beat is dropped.
   always_comb begin
      in_range_s  = ({1'b0, eff_sel_s} < N_S);
      sel_ready_s = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (eff_sel_s == SW'(k)) begin
            sel_ready_s = !out_valid_s[k] || out_ready[k];
         end else begin
            sel_ready_s = sel_ready_s;
         end
      end
   end

   assign in_ready  = sel_ready_s;
   assign in_xfer_s = in_valid && sel_ready_s;

   // Slot load decode: exactly the selected in-range slot on an input transfer.
   always_comb begin
      load_s = '0;
      for (int k = 0; k < N; k++) begin
         load_s[k] = in_xfer_s && (eff_sel_s == SW'(k));
      end
   end

   // Packet-lock FSM next-state logic.
   always_comb begin
      state_nxt_s    = state_r;
      lock_sel_nxt_s = lock_sel_r;
      case (state_r)
         IDLE: begin
            if (in_xfer_s && !in_last) begin
               state_nxt_s    = LOCK;
               lock_sel_nxt_s = in_sel;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOCK: begin
            if (in_xfer_s && in_last) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = LOCK;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state, locked select and drop-error pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         lock_sel_r <= '0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         lock_sel_r <= lock_sel_nxt_s;
         err_r      <= in_xfer_s && !in_range_s;
      end
   end

   assign err       = err_r;
   assign out_valid = out_valid_s;

   for (genvar k = 0; k < N; k++) begin : g_slot
      demux_slot #(
         .W (W)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load_s[k]),
         .in_data   (in_data),
         .in_last   (in_last),
         .ready     (out_ready[k]),
         .out_data  (out_data[k*W +: W]),
         .out_last  (out_last[k]),
         .out_valid (out_valid_s[k])
`ifdef DEMUX_CNT_EN
         ,
         .cnt       (beat_cnt[k*CNT_W +: CNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: self-checking bench for demux_stream (N=4 main instance,
// N=3 instance for out-of-range drops). Build with DEMUX_CNT_EN to include counters.
module tb_demux_stream;

   localparam int W  = 4;
   localparam int N  = 4;
   localparam int SW = 2;
   localparam int N3 = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   in_data;
   logic [SW-1:0]  in_sel;
   logic           in_last;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] out_data;
   logic [N-1:0]   out_last;
   logic [N-1:0]   out_valid;
   logic [N-1:0]   out_ready;
   logic           err;

   logic [W-1:0]    in_data3;
   logic [SW-1:0]   in_sel3;
   logic            in_last3;
   logic            in_valid3;
   logic            in_ready3;
   logic [N3*W-1:0] out_data3;
   logic [N3-1:0]   out_last3;
   logic [N3-1:0]   out_valid3;
   logic [N3-1:0]   out_ready3;
   logic            err3;

`ifdef DEMUX_CNT_EN
   logic [N*16-1:0]  beat_cnt;
   logic [N3*16-1:0] beat_cnt3;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   demux_stream #(.W(W), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
`ifdef DEMUX_CNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   demux_stream #(.W(W), .N(N3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_sel    (in_sel3),
      .in_last   (in_last3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_last  (out_last3),
      .out_valid (out_valid3),
      .out_ready (out_ready3),
      .err       (err3)
`ifdef DEMUX_CNT_EN
      ,
      .beat_cnt  (beat_cnt3)
`endif
   );

   task automatic idle_inputs();
      in_valid  = 1'b0; in_data  = '0; in_sel  = '0; in_last  = 1'b0;
      in_valid3 = 1'b0; in_data3 = '0; in_sel3 = '0; in_last3 = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      out_ready  = '1;
      out_ready3 = '1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [SW-1:0] s, input logic [W-1:0] d, input logic l);
      in_valid = 1'b1; in_sel = s; in_data = d; in_last = l;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      out_ready  = '1;
      out_ready3 = '1;
      repeat (2) @(negedge clk);
      #1;
      tests++; if (out_valid !== 4'b0000) begin fails++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
      tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h want 0000", out_data); end
      tests++; if (out_last !== 4'b0000) begin fails++; $display("FAIL reset_last: got %b want 0000", out_last); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [W-1:0] d;
      for (int ch = 0; ch < 4; ch++) begin
         @(negedge clk);
         d = 4'hA + ch[3:0];
         drive(ch[SW-1:0], d, 1'b1);
         #1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_ready ch%0d: got %b want 1", ch, in_ready); end
         @(posedge clk); #1;
         tests++; if (out_valid !== (4'b0001 << ch)) begin fails++; $display("FAIL single_valid ch%0d: got %b want %b", ch, out_valid, 4'b0001 << ch); end
         tests++; if (out_data[ch*W +: W] !== d) begin fails++; $display("FAIL single_data ch%0d: got %h want %h", ch, out_data[ch*W +: W], d); end
         tests++; if (out_last[ch] !== 1'b1) begin fails++; $display("FAIL single_last ch%0d: got %b want 1", ch, out_last[ch]); end
         in_valid = 1'b0;
      end
      @(posedge clk);
   endtask

   task automatic test_lock();
      logic [W-1:0]  pd [3];
      logic [SW-1:0] ps [3];
      logic          pl [3];
      pd = '{4'h1, 4'h2, 4'h3};
      ps = '{2'd2, 2'd0, 2'd0};
      pl = '{1'b0, 1'b0, 1'b1};
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         drive(ps[b], pd[b], pl[b]);
         #1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lock_ready b%0d: got %b want 1", b, in_ready); end
         @(posedge clk); #1;
         tests++; if (out_valid !== 4'b0100) begin fails++; $display("FAIL lock_valid b%0d: got %b want 0100", b, out_valid); end
         tests++; if (out_data[2*W +: W] !== pd[b]) begin fails++; $display("FAIL lock_data b%0d: got %h want %h", b, out_data[2*W +: W], pd[b]); end
         tests++; if (out_last[2] !== pl[b]) begin fails++; $display("FAIL lock_last b%0d: got %b want %b", b, out_last[2], pl[b]); end
      end
      @(negedge clk);
      drive(2'd0, 4'h7, 1'b1);
      @(posedge clk); #1;
      tests++; if (out_valid !== 4'b0001) begin fails++; $display("FAIL lock_unlock: got %b want 0001", out_valid); end
      in_valid = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      out_ready = 4'b0000;
      drive(2'd1, 4'h5, 1'b1);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_first_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 4'b0010 || out_data[W +: W] !== 4'h5) begin fails++; $display("FAIL stall_first: got v=%b d=%h want v=0010 d=5", out_valid, out_data[W +: W]); end
      @(negedge clk);
      drive(2'd1, 4'h6, 1'b1);
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_blocked: got %b want 0", in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid[1] !== 1'b1 || out_data[W +: W] !== 4'h5) begin fails++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=5", out_valid[1], out_data[W +: W]); end
      @(negedge clk);
      out_ready = 4'b0010;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_release: got %b want 1", in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 4'b0010 || out_data[W +: W] !== 4'h6) begin fails++; $display("FAIL b2b_second: got v=%b d=%h want v=0010 d=6", out_valid, out_data[W +: W]); end
      @(negedge clk);
      drive(2'd1, 4'h9, 1'b1);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 4'b0010 || out_data[W +: W] !== 4'h9) begin fails++; $display("FAIL b2b_third: got v=%b d=%h want v=0010 d=9", out_valid, out_data[W +: W]); end
      in_valid  = 1'b0;
      out_ready = '1;
      @(posedge clk);
   endtask

   task automatic test_drop();
      @(negedge clk);
      in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 4'hE; in_last3 = 1'b0;
      #1;
      tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL drop_ready0: got %b want 1", in_ready3); end
      @(posedge clk); #1;
      tests++; if (err3 !== 1'b1 || out_valid3 !== 3'b000) begin fails++; $display("FAIL drop_beat0: got err=%b v=%b want err=1 v=000", err3, out_valid3); end
      @(negedge clk);
      in_sel3 = 2'd0; in_data3 = 4'hF; in_last3 = 1'b1;
      #1;
      tests++; if (in_ready3 !== 1'b1) begin fails++; $display("FAIL drop_ready1: got %b want 1", in_ready3); end
      @(posedge clk); #1;
      tests++; if (err3 !== 1'b1 || out_valid3 !== 3'b000) begin fails++; $display("FAIL drop_beat1: got err=%b v=%b want err=1 v=000", err3, out_valid3); end
      @(negedge clk);
      in_valid3 = 1'b0;
      @(posedge clk); #1;
      tests++; if (err3 !== 1'b0) begin fails++; $display("FAIL drop_err_clear: got %b want 0", err3); end
      @(negedge clk);
      in_valid3 = 1'b1; in_sel3 = 2'd0; in_data3 = 4'h3; in_last3 = 1'b1;
      @(posedge clk); #1;
      tests++; if (out_valid3 !== 3'b001 || out_data3[W-1:0] !== 4'h3) begin fails++; $display("FAIL drop_after: got v=%b d=%h want v=001 d=3", out_valid3, out_data3[W-1:0]); end
      in_valid3 = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready = 4'b0000;
      drive(2'd2, 4'h8, 1'b1);
      @(negedge clk);
      drive(2'd3, 4'hC, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      tests++; if (out_valid !== 4'b0000 || out_data !== 16'h0000 || out_last !== 4'b0000) begin fails++; $display("FAIL resetmid_clear: got v=%b d=%h l=%b want all 0", out_valid, out_data, out_last); end
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = '1;
      drive(2'd1, 4'h4, 1'b1);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL resetmid_ready: got %b want 1", in_ready); end
      @(posedge clk); #1;
      tests++; if (out_valid !== 4'b0010 || out_data[W +: W] !== 4'h4) begin fails++; $display("FAIL resetmid_route: got v=%b d=%h want v=0010 d=4", out_valid, out_data[W +: W]); end
      in_valid = 1'b0;
      @(posedge clk);
   endtask

   // Random traffic against a beat-level model: each channel holds at most one
   // undelivered beat; a packet's destination is fixed by its first beat.
   task automatic test_random();
      bit           mfull [N];
      logic [W-1:0] mdata [N];
      bit           mlast [N];
      int           mcnt  [N];
      bit           locked;
      int           lock_dst;
      bit           hold;
      int           dst;
      bit           exp_rdy;
      do_reset();
      for (int k = 0; k < N; k++) begin mfull[k] = 0; mdata[k] = '0; mlast[k] = 0; mcnt[k] = 0; end
      locked = 0; lock_dst = 0; hold = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = W'($urandom_range(0, 15));
            in_sel   = SW'($urandom_range(0, 3));
            in_last  = ($urandom_range(0, 2) == 0);
         end
         out_ready = N'($urandom_range(0, 15));
         #1;
         dst     = locked ? lock_dst : int'(in_sel);
         exp_rdy = !mfull[dst] || out_ready[dst];
         tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, in_ready, exp_rdy); end
         for (int k = 0; k < N; k++) begin
            tests++; if (out_valid[k] !== mfull[k]) begin fails++; $display("FAIL rand_valid cyc%0d ch%0d: got %b want %b", cyc, k, out_valid[k], mfull[k]); end
            if (mfull[k]) begin
               tests++; if (out_data[k*W +: W] !== mdata[k] || out_last[k] !== mlast[k]) begin fails++; $display("FAIL rand_beat cyc%0d ch%0d: got %h/%b want %h/%b", cyc, k, out_data[k*W +: W], out_last[k], mdata[k], mlast[k]); end
            end
`ifdef DEMUX_CNT_EN
            tests++; if (beat_cnt[k*16 +: 16] !== mcnt[k][15:0]) begin fails++; $display("FAIL rand_cnt cyc%0d ch%0d: got %0d want %0d", cyc, k, beat_cnt[k*16 +: 16], mcnt[k][15:0]); end
`endif
         end
         for (int k = 0; k < N; k++) begin
            if (mfull[k] && out_ready[k]) begin mfull[k] = 0; mcnt[k]++; end
         end
         if (in_valid && exp_rdy) begin
            mfull[dst] = 1; mdata[dst] = in_data; mlast[dst] = in_last;
            if (!locked && !in_last) begin locked = 1; lock_dst = dst; end
            else if (locked && in_last) locked = 0;
            hold = 0;
         end else begin
            hold = in_valid;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = '1;
      @(posedge clk);
   endtask

`ifdef DEMUX_CNT_EN
   task automatic test_cnt_wrap();
      do_reset();
      drive(2'd0, 4'h1, 1'b1);
      repeat (65537) @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      tests++; if (beat_cnt[15:0] !== 16'd1) begin fails++; $display("FAIL cnt_wrap: got %0d want 1", beat_cnt[15:0]); end
      tests++; if (beat_cnt[N*16-1:16] !== 48'd0) begin fails++; $display("FAIL cnt_others: got %h want 0", beat_cnt[N*16-1:16]); end
   endtask
`endif

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_lock();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      test_random();
`ifdef DEMUX_CNT_EN
      test_cnt_wrap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
